// File: rtl/timekeeper_pkg.sv
// Shared BCD limits and helpers for the time-of-day core.
package timekeeper_pkg;

   localparam logic [7:0] BCD_MAX_MS = 8'h59;
   localparam logic [7:0] BCD_MAX_HR = 8'h23;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Once both nibbles are decimal, binary ordering matches BCD ordering.
   function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
      return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
   endfunction

   function automatic logic [7:0] hr24_to_12(input logic [7:0] h);
      logic [7:0] r;
      if (h == 8'h00)              r = 8'h12;
      else if (h <= 8'h12)         r = h;
      else if (h[7:4] == 4'd1)     r = {4'd0, h[3:0] - 4'd2};
      else if (h[3:0] < 4'd2)      r = {4'd0, h[3:0] + 4'd8};
      else                         r = {4'd1, h[3:0] - 4'd2};
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Packed-BCD modulo counter, 00..MAX, with load > clear > increment priority.
module bcd_mod_counter
   import timekeeper_pkg::*;
#(
   parameter logic [7:0] MAX = BCD_MAX_MS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic [7:0] nxt,
   output logic       wrap
);

   assign wrap = inc && (value == MAX);

   always_comb begin
      nxt = value;
      if (load)      nxt = load_val;
      else if (clr)  nxt = '0;
      else if (inc)  nxt = wrap ? '0 : bcd_inc(value);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value <= '0;
      else        value <= nxt;
   end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day core: 1 s prescaler, 24 h state, 12/24 h display, load/set.
// Optional alarm comparator built when BCD_TIMEKEEPER_ALARM_EN is defined.
module bcd_timekeeper
   import timekeeper_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int TICK_W   = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mode_12h,
   input  logic       load,
   input  logic [7:0] hr_in,
   input  logic [7:0] mn_in,
   input  logic [7:0] sd_in,
   input  logic       inc_hr,
   input  logic       inc_mn,
   input  logic       clr_sd,
   input  logic       al_wr,
   input  logic [7:0] al_hr,
   input  logic [7:0] al_mn,
   input  logic       al_on,
   output logic [7:0] hr,
   output logic [7:0] mn,
   output logic [7:0] sd,
   output logic       pm,
   output logic       tick_1s,
   output logic       day_pulse,
   output logic       load_err,
   output logic       alarm
);

   localparam logic [TICK_W-1:0] CNT_MAX = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] cnt;
   logic [7:0]        hr24, sd_nxt, mn_nxt, hr_nxt;
   logic              sd_wrap, mn_wrap, hr_wrap;
   logic              load_ok, set_clr, adv, al_rej;

   assign load_ok = load && bcd_valid(hr_in, BCD_MAX_HR)
                         && bcd_valid(mn_in, BCD_MAX_MS)
                         && bcd_valid(sd_in, BCD_MAX_MS);
   assign set_clr = clr_sd && !load;
   // Any load or set in the same cycle swallows the tick outright.
   assign adv     = tick_1s && en && !load && !inc_hr && !inc_mn && !clr_sd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         tick_1s <= 1'b0;
      end else begin
         tick_1s <= (cnt == CNT_MAX) && !set_clr;
         if (set_clr || cnt == CNT_MAX) cnt <= '0;
         else                           cnt <= cnt + 1'b1;
      end
   end

   bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_sd (
      .clk(clk), .rst_n(rst_n),
      .inc(adv), .clr(set_clr), .load(load_ok), .load_val(sd_in),
      .value(sd), .nxt(sd_nxt), .wrap(sd_wrap)
   );

   // Manual minute/hour bumps do not carry; only the tick chain does.
   bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_mn (
      .clk(clk), .rst_n(rst_n),
      .inc((adv && sd_wrap) || (inc_mn && !load)), .clr(1'b0),
      .load(load_ok), .load_val(mn_in),
      .value(mn), .nxt(mn_nxt), .wrap(mn_wrap)
   );

   bcd_mod_counter #(.MAX(BCD_MAX_HR)) u_hr (
      .clk(clk), .rst_n(rst_n),
      .inc((adv && sd_wrap && mn_wrap) || (inc_hr && !load)), .clr(1'b0),
      .load(load_ok), .load_val(hr_in),
      .value(hr24), .nxt(hr_nxt), .wrap(hr_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_pulse <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         day_pulse <= adv && sd_wrap && mn_wrap && hr_wrap;
         load_err  <= (load && !load_ok) || al_rej;
      end
   end

   assign hr = mode_12h ? hr24_to_12(hr24) : hr24;
   assign pm = (hr24 >= 8'h12);

`ifdef BCD_TIMEKEEPER_ALARM_EN
   logic [7:0] al_hr_q, al_mn_q;
   logic       al_arm_q, al_ok, alarm_q;

   assign al_ok  = bcd_valid(al_hr, BCD_MAX_HR) && bcd_valid(al_mn, BCD_MAX_MS);
   assign al_rej = al_wr && !al_ok;

   // Compare against the post-advance value so the pulse lines up with the new time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         al_hr_q  <= '0;
         al_mn_q  <= '0;
         al_arm_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         if (al_wr && al_ok) begin
            al_hr_q <= al_hr;
            al_mn_q <= al_mn;
         end
         al_arm_q <= al_on;
         alarm_q  <= al_arm_q && adv && sd_wrap
                     && (mn_nxt == al_mn_q) && (hr_nxt == al_hr_q);
      end
   end

   assign alarm = alarm_q;

   logic unused_sd_nxt;
   assign unused_sd_nxt = ^sd_nxt;
`else
   assign al_rej = 1'b0;
   assign alarm  = 1'b0;

   logic unused_alarm;
   assign unused_alarm = ^{al_wr, al_hr, al_mn, al_on, sd_nxt, mn_nxt, hr_nxt};
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Scoreboard bench for bcd_timekeeper with TICK_DIV=4; alarm expectations follow the build macro.
module tb_bcd_timekeeper;

`ifdef BCD_TIMEKEEPER_ALARM_EN
   localparam bit AL = 1'b1;
`else
   localparam bit AL = 1'b0;
`endif

   typedef struct {
      string      name;
      logic [7:0] hr, mn, sd;
      logic       pm, day, err, al;
      logic       tick_chk, tick;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, mode_12h = 1'b0, load = 1'b0;
   logic [7:0] hr_in = '0, mn_in = '0, sd_in = '0;
   logic       inc_hr = 1'b0, inc_mn = 1'b0, clr_sd = 1'b0;
   logic       al_wr = 1'b0, al_on = 1'b0;
   logic [7:0] al_hr = '0, al_mn = '0;
   logic [7:0] hr, mn, sd;
   logic       pm, tick_1s, day_pulse, load_err, alarm;

   logic       chk_req = 1'b0;
   exp_t       sb_q[$];
   int         n_chk = 0;
   int         n_fail = 0;

   bcd_timekeeper #(.TICK_DIV(4), .TICK_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode_12h(mode_12h), .load(load),
      .hr_in(hr_in), .mn_in(mn_in), .sd_in(sd_in),
      .inc_hr(inc_hr), .inc_mn(inc_mn), .clr_sd(clr_sd),
      .al_wr(al_wr), .al_hr(al_hr), .al_mn(al_mn), .al_on(al_on),
      .hr(hr), .mn(mn), .sd(sd), .pm(pm), .tick_1s(tick_1s),
      .day_pulse(day_pulse), .load_err(load_err), .alarm(alarm)
   );

   always #5 clk = ~clk;

   // Monitor: any pulse output or a driver check request consumes one expectation.
   always @(negedge clk) begin
      if (chk_req || day_pulse || load_err || alarm) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got hr=%h mn=%h sd=%h day=%b err=%b al=%b, required no output",
                     hr, mn, sd, day_pulse, load_err, alarm);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (hr !== e.hr || mn !== e.mn || sd !== e.sd || pm !== e.pm ||
                day_pulse !== e.day || load_err !== e.err || alarm !== e.al ||
                (e.tick_chk && tick_1s !== e.tick)) begin
               n_fail++;
               $display("FAIL %s: got %h:%h:%h pm=%b day=%b err=%b al=%b tick=%b, required %h:%h:%h pm=%b day=%b err=%b al=%b tick=%b(chk=%b)",
                        e.name, hr, mn, sd, pm, day_pulse, load_err, alarm, tick_1s,
                        e.hr, e.mn, e.sd, e.pm, e.day, e.err, e.al, e.tick, e.tick_chk);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string name, input logic [7:0] h, m, s,
                             input logic p, d, er, a,
                             input logic tc = 1'b0, input logic tk = 1'b0);
      exp_t e;
      e.name = name; e.hr = h; e.mn = m; e.sd = s; e.pm = p;
      e.day = d; e.err = er; e.al = a; e.tick_chk = tc; e.tick = tk;
      sb_q.push_back(e);
      chk_req = 1'b1;
      cyc();
      chk_req = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] h, m, s);
      hr_in = h; mn_in = m; sd_in = s; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      while (tick_1s !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      if (tick_1s !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL tick_timeout: tick_1s=%b after %0d cycles, required 1", tick_1s, n);
      end
   endtask

   initial begin
      // Reset state in both display modes
      cyc(); cyc();
      expect_now("reset_24h", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);
      mode_12h = 1'b1;
      expect_now("reset_12h", 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);
      mode_12h = 1'b0;
      rst_n = 1'b1;
      cyc();

      // Day rollover: 23:59:58 -> 23:59:59 -> 00:00:00 with one-cycle day_pulse
      do_load(8'h23, 8'h59, 8'h58);
      expect_now("load_235958", 8'h23, 8'h59, 8'h58, 1, 0, 0, 0);
      wait_tick();
      en = 1'b1;
      cyc();
      expect_now("tick_235959", 8'h23, 8'h59, 8'h59, 1, 0, 0, 0);
      cyc(); cyc(); cyc();
      en = 1'b0;
      expect_now("rollover_day", 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
      expect_now("rollover_after", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

      // 12 h decode at 00 / 12 / 13 / 23
      do_load(8'h00, 8'h34, 8'h56);
      expect_now("h00_24", 8'h00, 8'h34, 8'h56, 0, 0, 0, 0);
      mode_12h = 1'b1;
      expect_now("h00_12", 8'h12, 8'h34, 8'h56, 0, 0, 0, 0);
      do_load(8'h12, 8'h34, 8'h56);
      expect_now("h12_12", 8'h12, 8'h34, 8'h56, 1, 0, 0, 0);
      mode_12h = 1'b0;
      expect_now("h12_24", 8'h12, 8'h34, 8'h56, 1, 0, 0, 0);
      do_load(8'h13, 8'h34, 8'h56);
      expect_now("h13_24", 8'h13, 8'h34, 8'h56, 1, 0, 0, 0);
      mode_12h = 1'b1;
      expect_now("h13_12", 8'h01, 8'h34, 8'h56, 1, 0, 0, 0);
      do_load(8'h23, 8'h34, 8'h56);
      expect_now("h23_12", 8'h11, 8'h34, 8'h56, 1, 0, 0, 0);
      mode_12h = 1'b0;

      // Rejected loads leave state alone
      do_load(8'h24, 8'h00, 8'h00);
      expect_now("rej_hr24", 8'h23, 8'h34, 8'h56, 1, 0, 1, 0);
      do_load(8'h12, 8'h5A, 8'h00);
      expect_now("rej_mn5a", 8'h23, 8'h34, 8'h56, 1, 0, 1, 0);
      do_load(8'h12, 8'h00, 8'h60);
      expect_now("rej_sd60", 8'h23, 8'h34, 8'h56, 1, 0, 1, 0);

      // inc_mn beats a coincident tick; minute wrap does not carry
      do_load(8'h10, 8'h59, 8'h30);
      expect_now("load_105930", 8'h10, 8'h59, 8'h30, 0, 0, 0, 0);
      wait_tick();
      en = 1'b1; inc_mn = 1'b1;
      cyc();
      en = 1'b0; inc_mn = 1'b0;
      expect_now("inc_mn_tick", 8'h10, 8'h00, 8'h30, 0, 0, 0, 0);

      // inc_hr wraps 23 -> 00 without day_pulse; both increments together
      do_load(8'h23, 8'h15, 8'h20);
      inc_hr = 1'b1;
      cyc();
      inc_hr = 1'b0;
      expect_now("inc_hr_wrap", 8'h00, 8'h15, 8'h20, 0, 0, 0, 0);
      inc_hr = 1'b1; inc_mn = 1'b1;
      cyc();
      inc_hr = 1'b0; inc_mn = 1'b0;
      expect_now("inc_both", 8'h01, 8'h16, 8'h20, 0, 0, 0, 0);

      // clr_sd mid-prescale: next tick five cycles after the clear cycle
      do_load(8'h01, 8'h16, 8'h37);
      expect_now("load_011637", 8'h01, 8'h16, 8'h37, 0, 0, 0, 0);
      wait_tick();
      cyc();
      clr_sd = 1'b1;
      cyc();
      clr_sd = 1'b0;
      expect_now("clr_sd_c1", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0, 1, 0);
      expect_now("clr_sd_c2", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0, 1, 0);
      expect_now("clr_sd_c3", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0, 1, 0);
      expect_now("clr_sd_c4", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0, 1, 0);
      expect_now("clr_sd_c5", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0, 1, 1);

      // Alarm: bad write, good write, tick-driven hit
      al_on = 1'b1; al_hr = 8'h24; al_mn = 8'h00; al_wr = 1'b1;
      cyc();
      al_wr = 1'b0;
      expect_now("al_wr_rej", 8'h01, 8'h16, 8'h00, 0, 0, AL, 0);
      al_hr = 8'h07; al_wr = 1'b1;
      cyc();
      al_wr = 1'b0;
      expect_now("al_wr_ok", 8'h01, 8'h16, 8'h00, 0, 0, 0, 0);
      do_load(8'h06, 8'h59, 8'h58);
      expect_now("load_065958", 8'h06, 8'h59, 8'h58, 0, 0, 0, 0);
      wait_tick();
      en = 1'b1;
      cyc();
      expect_now("tick_065959", 8'h06, 8'h59, 8'h59, 0, 0, 0, 0);
      cyc(); cyc(); cyc();
      en = 1'b0;
      expect_now("alarm_hit", 8'h07, 8'h00, 8'h00, 0, 0, 0, AL);
      expect_now("alarm_after", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);

      // Loading the alarm time directly does not fire
      do_load(8'h07, 8'h00, 8'h00);
      expect_now("alarm_load", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);

      // Disarmed: tick into alarm time stays quiet
      al_on = 1'b0;
      do_load(8'h06, 8'h59, 8'h59);
      wait_tick();
      en = 1'b1;
      cyc();
      en = 1'b0;
      expect_now("alarm_off", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);

      cyc(); cyc();
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

Parametrised BCD time-of-day core, successor to the fixed 24-hour clock block in the digital-clock design. Prescales `clk` to a 1 s tick and keeps hours/minutes/seconds as packed BCD. Adds runtime 12/24-hour display, validated load, per-field set buttons, day-rollover and tick outputs, and an optional alarm comparator. Feeds the display mux and the alarm/buzzer logic.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per 1 s tick (≥2).
- `TICK_W`, default 26: prescaler width; must satisfy 2^TICK_W ≥ TICK_DIV.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable; 0 freezes time, prescaler keeps counting.
- `mode_12h` in 1: display mode; 1 = 12 h, 0 = 24 h.
- `load` in 1: load `hr_in/mn_in/sd_in` (24 h BCD).
- `hr_in`, `mn_in`, `sd_in` in 8 each: load values.
- `inc_hr`, `inc_mn` in 1: single-cycle field increment strobes.
- `clr_sd` in 1: zero seconds and prescaler.
- `al_wr` in 1, `al_hr`/`al_mn` in 8, `al_on` in 1: alarm set/arm (macro only).
- `hr`, `mn`, `sd` out 8: BCD time; `hr` is in display mode.
- `pm` out 1: 1 when internal hour ≥ 12 (valid in both modes).
- `tick_1s` out 1: one-cycle pulse per second.
- `day_pulse` out 1: one-cycle pulse on 23:59:59 → 00:00:00.
- `load_err` out 1: one-cycle pulse when a load/al_wr is rejected.
- `alarm` out 1: one-cycle alarm pulse.

## Operation
- Internal state always 24 h: `hr24` 00–23, `mn`/`sd` 00–59, packed BCD.
- Prescaler counts 0..TICK_DIV-1, then wraps; `tick_1s` is registered, high in the cycle after the count hits TICK_DIV-1.
- On an edge with `tick_1s`=1 and `en`=1, time advances by one second with BCD carry through sd → mn → hr24. 23:59:59 wraps to 00:00:00 and registers `day_pulse`.
- Same-cycle priority: `load` > `inc_hr`/`inc_mn`/`clr_sd` > tick. A tick that loses to load or set is discarded, not deferred. `inc_hr` and `inc_mn` may coincide; both apply.
- `inc_hr`: 23 → 00, no day_pulse. `inc_mn`: 59 → 00, no carry into hr. Both act regardless of `en`.
- `clr_sd`: sd=00; prescaler restarts at 0.
- Load validation: rejected if any nibble > 9, hr > 23, or mn/sd > 59. On rejection, state is unchanged and `load_err` pulses.
- 12 h decode is combinational from `hr24`: 00 → 12, 01–12 unchanged, 13–23 → hr24−12 (BCD). Toggling `mode_12h` never alters state.

## Timing
- Reset values: hr24=mn=sd=00, prescaler 0, all pulses 0, alarm registers 00 and disarmed. In 12 h mode `hr` reads 12 with pm=0.
- New time is visible the cycle after the `tick_1s`/load/set edge. `hr`/`pm` follow `mode_12h` combinationally.
- `day_pulse` and `alarm` are coincident with the first cycle showing the new time.
- Asserting `rst_n` mid-count clears everything immediately. The first tick comes TICK_DIV+1 cycles after release.

## Configuration
- `BCD_TIMEKEEPER_ALARM_EN` defined:
  - `al_wr` stores `al_hr`/`al_mn` with the same validation (a reject pulses `load_err`).
  - `alarm` pulses when a tick advance produces exactly al_hr:al_mn:00 and `al_on`=1.
  - Load/set reaching that time does not fire.
- Undefined: alarm ports remain, inputs are ignored, `alarm` is tied 0, and no alarm registers are built.

## Structure
- `timekeeper_pkg`:
  - BCD limit constants (59, 23).
  - Functions `bcd_inc`, `bcd_valid(val, max)`, `hr24_to_12`.
- Sub-module `bcd_mod_counter`:
  - Parameter MAX; inputs inc/clr/load.
  - Outputs value and wrap carry.
  - Instanced for sd, mn, hr24.

## Test plan
- TICK_DIV=4, en=1, load 23:59:58:
  - Two ticks → 23:59:59, then 00:00:00.
  - `day_pulse` high in exactly one cycle.
- mode_12h toggled at hr24=00/12/13 → `hr` reads 12/12/01, pm 0/1/1; mn/sd unchanged.
- Load hr_in=24, then mn_in=8'h5A → `load_err` pulses each time, state unchanged.
- `inc_mn` coincident with `tick_1s` at 10:59:30 → 10:00:30, tick discarded. `inc_hr` at 23 → 00, no day_pulse.
- `clr_sd` at sd=37 mid-prescale → sd=00, next tick 5 cycles later.
- ALARM_EN build:
  - al_wr 07:00, al_on=1, run from 06:59:58 → `alarm` one cycle at 07:00:00.
  - Direct load of 07:00:00 → no alarm.
  - al_on=0 → no alarm.
